ps2_keyboard_tx: RTL and testbench

//   Device-side PS/2 keyboard emulator. It serialises scan codes onto ps2_clk/ps2_data for the

---
 rtl/ps2_keyboard_tx_if.sv | 21 ++
 rtl/ps2_keyboard_tx.sv | 118 +++++++++++
 tb/tb_ps2_keyboard_tx.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_keyboard_tx_if.sv
// Request/handshake and PS/2 line bundle between a key source and the keyboard emulator.
// The master drives requests and observes the line; the slave is the emulator itself.
interface ps2_keyboard_tx_if;
   logic [7:0] key_code;
   logic       send_make;
   logic       send_break;
   logic       ready;
   logic       done;
   logic       ps2_clk;
   logic       ps2_data;

   modport master (
      output key_code, send_make, send_break,
      input  ready, done, ps2_clk, ps2_data
   );

   modport slave (
      input  key_code, send_make, send_break,
      output ready, done, ps2_clk, ps2_data
   );
endinterface

// File: rtl/ps2_keyboard_tx.sv
// PS/2 device-side emulator: serialises make (code) or break (F0, code) onto ps2_clk/ps2_data.
// done fires 2+22*CLK_DIV+GAP_CYCLES cycles after accept per make; requests are dropped while ready=0.
module ps2_keyboard_tx #(
   parameter int CLK_DIV    = 4096,
   parameter int GAP_CYCLES = 8192
) (
   input logic clk,
   input logic reset,
   ps2_keyboard_tx_if.slave bus
);

   localparam int HW = $clog2(CLK_DIV);
   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      BIT_HI,
      BIT_LO,
      GAP,
      DONE
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [HW-1:0]   half_cnt;
   logic [GW-1:0]   gap_cnt;
   logic [3:0]      bit_cnt;
   logic [10:0]     frame;
   logic [7:0]      code_q;
   logic            brk_q;
   logic            second_q;

   logic            accept;
   logic            half_end;
   logic            gap_end;
   logic            last_bit;
   logic            first_of_break;
   logic [7:0]      shift_byte;

   assign accept         = (state == IDLE) && (bus.send_make || bus.send_break);
   assign half_end       = (half_cnt == HW'(CLK_DIV - 1));
   assign gap_end        = (gap_cnt == GW'(GAP_CYCLES - 1));
   assign last_bit       = (bit_cnt == 4'd10);
   assign first_of_break = brk_q && !second_q;
   assign shift_byte     = first_of_break ? 8'hF0 : code_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = LOAD;
         LOAD:    state_nxt = BIT_HI;
         BIT_HI:  if (half_end) state_nxt = BIT_LO;
         BIT_LO:  if (half_end) state_nxt = last_bit ? GAP : BIT_HI;
         GAP:     if (gap_end) state_nxt = first_of_break ? LOAD : DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         half_cnt <= '0;
         gap_cnt  <= '0;
         bit_cnt  <= '0;
         frame    <= '1;
         code_q   <= '0;
         brk_q    <= 1'b0;
         second_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  code_q   <= bus.key_code;
                  // make has priority when both requests arrive together
                  brk_q    <= bus.send_break && !bus.send_make;
                  second_q <= 1'b0;
               end
            end
            LOAD: begin
               frame    <= {1'b1, ~^shift_byte, shift_byte, 1'b0};
               bit_cnt  <= '0;
               half_cnt <= '0;
            end
            BIT_HI: begin
               half_cnt <= half_end ? '0 : half_cnt + 1'b1;
            end
            BIT_LO: begin
               half_cnt <= half_end ? '0 : half_cnt + 1'b1;
               if (half_end) begin
                  frame <= {1'b1, frame[10:1]};
                  if (!last_bit) bit_cnt <= bit_cnt + 1'b1;
               end
            end
            GAP: begin
               gap_cnt <= gap_end ? '0 : gap_cnt + 1'b1;
               if (gap_end && first_of_break) second_q <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Data only moves when the frame shifts at the end of a low phase, so it is stable while ps2_clk=0.
   assign bus.ready    = (state == IDLE);
   assign bus.done     = (state == DONE);
   assign bus.ps2_clk  = (state != BIT_LO);
   assign bus.ps2_data = (state == BIT_HI || state == BIT_LO) ? frame[0] : 1'b1;

endmodule

// File: tb/tb_ps2_keyboard_tx.sv
// Scoreboard bench for ps2_keyboard_tx with CLK_DIV=4, GAP_CYCLES=8.
// Stimulus pushes expected frames/latencies; a negedge monitor decodes the line and checks them.
module tb_ps2_keyboard_tx;

   typedef struct {
      logic [7:0] b;
      logic       p;
   } exp_t;

   logic clk;
   logic reset;
   ps2_keyboard_tx_if bus ();

   ps2_keyboard_tx #(.CLK_DIV(4), .GAP_CYCLES(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   n_tests = 0;
   int   n_fail  = 0;
   exp_t byte_q[$];
   int   lat_q[$];

   int          cyc = 0;
   int          acc_cyc = 0;
   bit          acc_vld = 0;
   bit          first_fall = 0;
   int          fall_total = 0;
   int          fidx = 0;
   logic [10:0] frm = '0;
   int          stop_cyc = 0;
   bit          stop_vld = 0;
   bit          gap_ok = 1;
   logic        prev_clk = 1'b1;
   logic        prev_data = 1'b1;

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic flag(input string name);
      n_tests++;
      n_fail++;
      $display("FAIL %s: event occurred, expected none", name);
   endtask

   // Monitor: decodes frames on ps2_clk falls and checks timing against the scoreboard.
   always @(negedge clk) begin
      exp_t e;
      int   lat;
      cyc++;
      if (reset) begin
         byte_q.delete();
         lat_q.delete();
         fidx       = 0;
         acc_vld    = 0;
         first_fall = 0;
         stop_vld   = 0;
         gap_ok     = 1;
      end else begin
         if (bus.ready && (bus.send_make || bus.send_break)) begin
            acc_cyc    = cyc;
            acc_vld    = 1;
            first_fall = 1;
         end
         if (acc_vld && cyc == acc_cyc + 2)
            chk("start_bit_time", int'(bus.ps2_data), 0);
         if (!prev_clk && !bus.ps2_clk && bus.ps2_data !== prev_data)
            flag("data_change_while_clk_low");
         if (prev_clk && !bus.ps2_clk) begin
            fall_total++;
            if (first_fall) begin
               chk("first_fall_time", cyc - acc_cyc, 6);
               first_fall = 0;
            end
            frm[fidx] = bus.ps2_data;
            fidx++;
            if (fidx == 11) begin
               fidx     = 0;
               stop_cyc = cyc;
               stop_vld = 1;
               gap_ok   = 1;
               if (byte_q.size() == 0) begin
                  flag("unexpected_byte");
               end else begin
                  e = byte_q.pop_front();
                  chk("frame", 32'(frm), 32'({1'b1, e.p, e.b, 1'b0}));
               end
            end
         end
         if (stop_vld && cyc >= stop_cyc + 4 && cyc <= stop_cyc + 11) begin
            if (!(bus.ps2_clk && bus.ps2_data)) gap_ok = 0;
            if (cyc == stop_cyc + 11) begin
               chk("gap_high", int'(gap_ok), 1);
               stop_vld = 0;
            end
         end
         if (bus.done) begin
            if (lat_q.size() == 0) begin
               flag("unexpected_done");
            end else begin
               lat = lat_q.pop_front();
               chk("done_latency", cyc - acc_cyc, lat);
            end
            acc_vld = 0;
         end
      end
      prev_clk  = bus.ps2_clk;
      prev_data = bus.ps2_data;
   end

   task automatic push_byte(input logic [7:0] b, input logic p);
      exp_t e;
      e.b = b;
      e.p = p;
      byte_q.push_back(e);
   endtask

   task automatic request(input logic [7:0] code, input logic mk, input logic bk);
      int t;
      t = 0;
      @(posedge clk); #1;
      while (!bus.ready && t < 1000) begin
         @(posedge clk); #1;
         t++;
      end
      if (t >= 1000) flag("ready_timeout");
      bus.key_code   = code;
      bus.send_make  = mk;
      bus.send_break = bk;
      @(posedge clk); #1;
      bus.send_make  = 1'b0;
      bus.send_break = 1'b0;
      bus.key_code   = 8'hAA;
   endtask

   task automatic wait_idle(input string name);
      int t;
      t = 0;
      while ((byte_q.size() != 0 || lat_q.size() != 0) && t < 2000) begin
         @(posedge clk); #1;
         t++;
      end
      if (t >= 2000) flag({name, "_timeout"});
      @(negedge clk);
      chk({name, "_ready_back"}, int'(bus.ready), 1);
   endtask

   initial begin
      int base;
      int t;
      reset          = 1'b1;
      bus.key_code   = 8'h00;
      bus.send_make  = 1'b0;
      bus.send_break = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("rst_ready", int'(bus.ready), 1);
      chk("rst_done", int'(bus.done), 0);
      chk("rst_ps2_clk", int'(bus.ps2_clk), 1);
      chk("rst_ps2_data", int'(bus.ps2_data), 1);

      // 1: make 0x1C
      push_byte(8'h1C, 1'b0);
      lat_q.push_back(98);
      request(8'h1C, 1'b1, 1'b0);
      wait_idle("make_1c");

      // 2: break 0x1C
      push_byte(8'hF0, 1'b1);
      push_byte(8'h1C, 1'b0);
      lat_q.push_back(195);
      request(8'h1C, 1'b0, 1'b1);
      wait_idle("break_1c");

      // 3: parity corners
      push_byte(8'h00, 1'b1);
      lat_q.push_back(98);
      request(8'h00, 1'b1, 1'b0);
      wait_idle("make_00");
      push_byte(8'hFF, 1'b1);
      lat_q.push_back(98);
      request(8'hFF, 1'b1, 1'b0);
      wait_idle("make_ff");
      push_byte(8'h01, 1'b0);
      lat_q.push_back(98);
      request(8'h01, 1'b1, 1'b0);
      wait_idle("make_01");

      // 4: request while busy is ignored
      push_byte(8'h1C, 1'b0);
      lat_q.push_back(98);
      request(8'h1C, 1'b1, 1'b0);
      repeat (20) @(posedge clk);
      #1;
      bus.key_code  = 8'h22;
      bus.send_make = 1'b1;
      @(posedge clk); #1;
      bus.send_make = 1'b0;
      wait_idle("busy_ignore");

      // 5: make wins over break
      push_byte(8'h15, 1'b0);
      lat_q.push_back(98);
      request(8'h15, 1'b1, 1'b1);
      wait_idle("make_wins");

      // 6: reset at the 5th falling edge
      base = fall_total;
      push_byte(8'h1C, 1'b0);
      lat_q.push_back(98);
      request(8'h1C, 1'b1, 1'b0);
      t = 0;
      while (fall_total < base + 5 && t < 500) begin
         @(negedge clk);
         t++;
      end
      if (t >= 500) flag("fall5_timeout");
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk("midrst_ps2_clk", int'(bus.ps2_clk), 1);
      chk("midrst_ps2_data", int'(bus.ps2_data), 1);
      chk("midrst_ready", int'(bus.ready), 1);
      repeat (150) @(posedge clk);
      push_byte(8'h1C, 1'b0);
      lat_q.push_back(98);
      request(8'h1C, 1'b1, 1'b0);
      wait_idle("after_reset");

      repeat (5) @(posedge clk);
      chk("queues_empty", byte_q.size() + lat_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
